// File: rtl/bitsim_sched_pkg.sv
// Shared types and helpers for the bit-serial bitmask scheduler.
// Holds the scheduler state encoding, mask/index widths and the
// bit-clear helper used when a beat retires one set bit.
package bitsim_sched_pkg;

  localparam int MASK_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sched_state_e;

  // Clear the bit addressed by an MSB-first index (0 = bit 7).
  function automatic logic [MASK_W-1:0] clr_bit(input logic [MASK_W-1:0] mask,
                                                input logic [IDX_W-1:0]  idx);
    return mask & ~(8'h80 >> idx);
  endfunction

endpackage

// File: rtl/p_encoder_8to3.sv
// 8-to-3 priority encoder, leading one from the MSB.
// idx = 0 means bit 7 is the highest set bit, idx = 7 means bit 0.
// is_zero flags an all-zero input (idx is then 0).
module p_encoder_8to3 (
  input  logic [7:0] in_bits,
  output logic [2:0] idx,
  output logic       is_zero
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    idx     = 3'd0;
    is_zero = (in_bits == 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (in_bits[i]) idx = 3'(7 - i);
    end
  end

endmodule

// File: rtl/bitmask_scheduler.sv
// Bitmask scheduler: decomposes one 8-bit mask per transaction into one
// output beat per set bit, MSB-first, for the bit-serial PE array.
// An all-zero mask yields a single beat flagged out_zero.
// Optional build macro BITMASK_SCHED_SKIP_ZERO_EN: all-zero masks are
// consumed silently with no output beat, and out_zero is tied low.
module bitmask_scheduler
  import bitsim_sched_pkg::*;
#(
  parameter int TAG_W  = 8,
  parameter int MASK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_mask,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_idx,
  output logic [2:0]       out_seq,
  output logic             out_last,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  if (MASK_W != 8) begin : g_bad_mask_w
    $error("bitmask_scheduler: MASK_W must be 8");
  end

  sched_state_e     state_q;
  logic [7:0]       mask_q;
  logic [TAG_W-1:0] tag_q;
  logic [2:0]       seq_q;
  logic             zero_q;

  logic             enc_zero;
  logic             in_fire;
  logic             out_fire;
  logic             skip_hit;

  p_encoder_8to3 u_enc (
    .in_bits (mask_q),
    .idx     (out_idx),
    .is_zero (enc_zero)
  );

  assign out_valid = (state_q == SCAN);
  assign busy      = (state_q == SCAN);
  assign out_seq   = seq_q;
  assign out_tag   = tag_q;
  // Last beat when at most one bit remains; a zero transaction is one beat.
  assign out_last  = zero_q | ((mask_q & (mask_q - 8'd1)) == 8'd0);

  assign out_fire  = out_valid & out_ready;
  // Accepting on the last-beat handshake gives zero-bubble back-to-back.
  assign in_ready  = (state_q == IDLE) | (out_fire & out_last);
  assign in_fire   = in_valid & in_ready;

`ifdef BITMASK_SCHED_SKIP_ZERO_EN
  assign skip_hit  = in_fire & (in_mask == 8'h00);
  assign out_zero  = 1'b0;
`else
  assign skip_hit  = 1'b0;
  assign out_zero  = zero_q;
`endif

  // Transaction load, per-beat bit retirement and return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= 8'h00;
      tag_q   <= '0;
      seq_q   <= 3'd0;
      zero_q  <= 1'b0;
    end else if (in_fire && !skip_hit) begin
      state_q <= SCAN;
      mask_q  <= in_mask;
      tag_q   <= in_tag;
      seq_q   <= 3'd0;
      zero_q  <= (in_mask == 8'h00);
    end else if (out_fire) begin
      if (out_last) begin
        state_q <= IDLE;
      end else begin
        mask_q <= clr_bit(mask_q, out_idx);
        seq_q  <= seq_q + 3'd1;
      end
    end
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_idx) && $stable(out_seq) &&
                                   $stable(out_last) && $stable(out_zero) && $stable(out_tag)));

  a_idx_set: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !zero_q) |-> mask_q[3'd7 - out_idx]);

  a_enc_zero: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> (enc_zero == zero_q));

endmodule

// File: tb/tb_bitmask_scheduler.sv
// Directed and randomized bench for bitmask_scheduler.
module tb_bitmask_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_mask = 8'h00;
  logic [7:0] in_tag = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_idx;
  logic [2:0] out_seq;
  logic       out_last;
  logic       out_zero;
  logic [7:0] out_tag;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bitmask_scheduler #(.TAG_W(8), .MASK_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_seq   (out_seq),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int popcount8(input logic [7:0] m);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m[i]);
    return n;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
        errors++; $display("FAIL reset_state got v/b/r=%b exp 001", {out_valid, busy, in_ready});
      end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if ({out_valid, busy, in_ready, out_seq, out_zero} !== 7'b0010000) begin
      errors++; $display("FAIL reset_release got v/b/r/seq/z=%b exp 0010000",
                         {out_valid, busy, in_ready, out_seq, out_zero});
    end
  endtask

  task automatic test_basic();
    logic [2:0] e_idx [3] = '{3'd0, 3'd2, 3'd5};
    @(negedge clk); in_valid = 1'b1; in_mask = 8'hA4; in_tag = 8'h3C; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({out_valid, out_idx, out_seq, out_last, out_zero, out_tag} !==
          {1'b1, e_idx[i], 3'(i), (i == 2), 1'b0, 8'h3C}) begin
        errors++; $display("FAIL basic_beat%0d got v=%b idx=%0d seq=%0d last=%b z=%b tag=%h exp idx=%0d seq=%0d last=%0d tag=3c",
                           i, out_valid, out_idx, out_seq, out_last, out_zero, out_tag, e_idx[i], i, (i == 2));
      end
      checks++;
      if (in_ready !== (i == 2)) begin
        errors++; $display("FAIL basic_in_ready%0d got %b exp %0d", i, in_ready, (i == 2));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL basic_idle got v/b=%b exp 00", {out_valid, busy});
    end
  endtask

  task automatic test_zero();
    @(negedge clk); in_valid = 1'b1; in_mask = 8'h00; in_tag = 8'h5A; out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_accept got in_ready=%b exp 1", in_ready);
    end
    @(negedge clk); in_valid = 1'b0; #1;
`ifdef BITMASK_SCHED_SKIP_ZERO_EN
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++; $display("FAIL zero_skip got v/b/r=%b exp 001", {out_valid, busy, in_ready});
    end
`else
    checks++;
    if ({out_valid, out_zero, out_last, out_idx, out_seq, out_tag} !==
        {1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 8'h5A}) begin
      errors++; $display("FAIL zero_beat got v=%b z=%b last=%b idx=%0d seq=%0d tag=%h exp 1 1 1 0 0 5a",
                         out_valid, out_zero, out_last, out_idx, out_seq, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_last_ready got %b exp 1", in_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_single got out_valid=%b exp 0", out_valid);
    end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk); in_valid = 1'b1; in_mask = 8'hFF; in_tag = 8'h11; out_ready = 1'b1;
    @(negedge clk); in_mask = 8'h01; in_tag = 8'h22;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({out_valid, out_idx, out_seq, out_last, out_tag} !== {1'b1, 3'(i), 3'(i), (i == 7), 8'h11}) begin
        errors++; $display("FAIL b2b_beat%0d got v=%b idx=%0d seq=%0d last=%b tag=%h exp idx=%0d seq=%0d last=%0d tag=11",
                           i, out_valid, out_idx, out_seq, out_last, out_tag, i, i, (i == 7));
      end
      checks++;
      if (in_ready !== (i == 7)) begin
        errors++; $display("FAIL b2b_in_ready%0d got %b exp %0d", i, in_ready, (i == 7));
      end
      @(negedge clk);
    end
    in_valid = 1'b0; #1;
    checks++;
    if ({out_valid, busy, out_idx, out_seq, out_last, out_tag} !== {1'b1, 1'b1, 3'd7, 3'd0, 1'b1, 8'h22}) begin
      errors++; $display("FAIL b2b_second got v=%b b=%b idx=%0d seq=%0d last=%b tag=%h exp 1 1 7 0 1 22",
                         out_valid, busy, out_idx, out_seq, out_last, out_tag);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_stall();
    @(negedge clk); in_valid = 1'b1; in_mask = 8'h81; in_tag = 8'h77; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({out_valid, out_idx, out_seq, out_last, out_tag, in_ready} !==
          {1'b1, 3'd0, 3'd0, 1'b0, 8'h77, 1'b0}) begin
        errors++; $display("FAIL stall_hold%0d got v=%b idx=%0d seq=%0d last=%b tag=%h rdy=%b exp 1 0 0 0 77 0",
                           i, out_valid, out_idx, out_seq, out_last, out_tag, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; #1;
    checks++;
    if ({out_idx, in_ready} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL stall_release got idx=%0d rdy=%b exp 0 0", out_idx, in_ready);
    end
    @(negedge clk); #1;
    checks++;
    if ({out_valid, out_idx, out_seq, out_last, in_ready} !== {1'b1, 3'd7, 3'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL stall_second got v=%b idx=%0d seq=%0d last=%b rdy=%b exp 1 7 1 1 1",
                         out_valid, out_idx, out_seq, out_last, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); in_valid = 1'b1; in_mask = 8'hF0; in_tag = 8'h44; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if ({out_valid, out_idx} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL rmid_beat0 got v=%b idx=%0d exp 1 0", out_valid, out_idx);
    end
    @(negedge clk); #1;
    checks++;
    if ({out_valid, out_idx, out_seq} !== {1'b1, 3'd1, 3'd1}) begin
      errors++; $display("FAIL rmid_beat1 got v=%b idx=%0d seq=%0d exp 1 1 1", out_valid, out_idx, out_seq);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL rmid_async got v/b=%b exp 00", {out_valid, busy});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL rmid_release got rdy/v=%b exp 10", {in_ready, out_valid});
    end
    @(negedge clk); in_valid = 1'b1; in_mask = 8'h02; in_tag = 8'h99;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if ({out_valid, out_idx, out_seq, out_last, out_tag} !== {1'b1, 3'd6, 3'd0, 1'b1, 8'h99}) begin
      errors++; $display("FAIL rmid_new got v=%b idx=%0d seq=%0d last=%b tag=%h exp 1 6 0 1 99",
                         out_valid, out_idx, out_seq, out_last, out_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] m;
    logic [7:0] t;
    int         exp_n;
    int         n;
    int         prev;
    bit         done;
    for (int k = 0; k < 2000; k++) begin
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      t = 8'($urandom);
`ifdef BITMASK_SCHED_SKIP_ZERO_EN
      exp_n = (m == 8'h00) ? 0 : popcount8(m);
`else
      exp_n = (m == 8'h00) ? 1 : popcount8(m);
`endif
      @(negedge clk); in_valid = 1'b1; in_mask = m; in_tag = t; out_ready = 1'b0; #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL rnd_idle%0d got in_ready=%b exp 1", k, in_ready);
      end
      @(negedge clk); in_valid = 1'b0;
      if (exp_n == 0) begin
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_skip%0d got out_valid=%b exp 0", k, out_valid);
        end
        continue;
      end
      n = 0; prev = -1; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (out_valid && out_ready) begin
          checks++;
          if (int'(out_idx) <= prev || out_seq !== 3'(n) || out_tag !== t ||
              (m != 8'h00 && m[3'd7 - out_idx] !== 1'b1)) begin
            errors++; $display("FAIL rnd_beat%0d mask=%h got idx=%0d seq=%0d tag=%h exp idx>%0d seq=%0d tag=%h",
                               k, m, out_idx, out_seq, out_tag, prev, n, t);
          end
          prev = int'(out_idx);
          n++;
          if (out_last) done = 1'b1;
        end
        if (!done) @(negedge clk);
      end
      checks++;
      if (!done || n != exp_n) begin
        errors++; $display("FAIL rnd_count%0d mask=%h got beats=%0d done=%0d exp %0d", k, m, n, done, exp_n);
      end
    end
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
